md_issue_ctrl: RTL and testbench

- Execute-stage sequencer for the multi-cycle multdiv unit inside the ALU.
- Detects MUL/DIV ALU opcodes and latches the operands and destination. Issues a one-cycle ctrl_MULT/ctrl_DIV pulse, then stalls the pipeline until data_resultRDY.
- Produces a single-cycle writeback; a multdiv exception is converted into a status-register write.
- Single-cycle ALU ops bypass it (stall=0).

---
 rtl/md_issue_ctrl_pkg.sv | 24 ++
 rtl/md_issue_ctrl_if.sv | 24 ++
 rtl/md_issue_ctrl_wb_format.sv | 19 +
 rtl/md_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared opcodes, state encoding and status constants for the multdiv issue sequencer.
// The optional watchdog is enabled with `define MD_TIMEOUT_EN.
package md_issue_ctrl_pkg;

    localparam logic [4:0]  OP_MUL         = 5'b00110;
    localparam logic [4:0]  OP_DIV         = 5'b00111;
    localparam logic [4:0]  STATUS_REG     = 5'd30;
    localparam logic [31:0] EXC_MUL        = 32'd4;
    localparam logic [31:0] EXC_DIV        = 32'd5;
    localparam int          TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } md_state_e;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Operand/control/result bundle between the issue sequencer and the multdiv unit.
// master = sequencer side, slave = multdiv side.
interface md_issue_ctrl_if;

    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        md_inputRDY;
    logic        md_resultRDY;
    logic [31:0] md_result;
    logic        md_exception;

    modport master (
        output md_opA, md_opB, ctrl_MULT, ctrl_DIV,
        input  md_inputRDY, md_resultRDY, md_result, md_exception
    );

    modport slave (
        input  md_opA, md_opB, ctrl_MULT, ctrl_DIV,
        output md_inputRDY, md_resultRDY, md_result, md_exception
    );

endinterface

// File: rtl/md_issue_ctrl_wb_format.sv
// Remaps a multdiv result into its writeback form; an exception becomes
// a status-register write carrying the per-op exception code.
module md_wb_format
    import md_issue_ctrl_pkg::*;
(
    input  logic        exc_i,
    input  logic        is_div_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] result_i,
    output logic [4:0]  rd_o,
    output logic [31:0] data_o,
    output logic        exc_o
);

    assign rd_o   = exc_i ? STATUS_REG : rd_i;
    assign data_o = exc_i ? (is_div_i ? EXC_DIV : EXC_MUL) : result_i;
    assign exc_o  = exc_i;

endmodule

// File: rtl/md_issue_ctrl.sv
// Execute-stage sequencer for the multi-cycle multdiv unit: issue, stall, writeback.
// `define MD_TIMEOUT_EN adds a watchdog that bounds BUSY/DRAIN.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       in_opcode,
    input  logic [31:0]      in_opA,
    input  logic [31:0]      in_opB,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic             stall,
    md_issue_ctrl_if.master  md,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             wb_exception
);

    md_state_e   state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_div_q, is_div_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic        wbv_q, wbv_d;
    logic        wbwe_q, wbwe_d;
    logic [4:0]  wbrd_q, wbrd_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        wbexc_q, wbexc_d;

    logic        is_md;
    logic        tmo_hit;
    logic        fmt_exc;
    logic [4:0]  fmt_rd;
    logic [31:0] fmt_data;
    logic        fmt_exc_o;

    assign is_md = in_valid & is_md_op(in_opcode);

`ifdef MD_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       waiting;

    assign waiting = (state_q == BUSY) || (state_q == DRAIN);
    assign wdog_d  = waiting ? wdog_q + 8'd1 : 8'd0;
    assign tmo_hit = waiting && (wdog_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) wdog_q <= 8'd0;
        else       wdog_q <= wdog_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // A real result takes priority over a watchdog expiry in the same cycle
    assign fmt_exc = md.md_resultRDY ? md.md_exception : tmo_hit;

    md_wb_format u_fmt (
        .exc_i    (fmt_exc),
        .is_div_i (is_div_q),
        .rd_i     (rd_q),
        .result_i (md.md_result),
        .rd_o     (fmt_rd),
        .data_o   (fmt_data),
        .exc_o    (fmt_exc_o)
    );

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        is_div_d = is_div_q;
        mult_d   = 1'b0;
        div_d    = 1'b0;
        wbv_d    = 1'b0;
        wbwe_d   = 1'b0;
        wbrd_d   = 5'd0;
        wbdata_d = 32'd0;
        wbexc_d  = 1'b0;
        stall    = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = is_md;
                if (is_md && md.md_inputRDY && !flush) begin
                    state_d  = START;
                    opa_d    = in_opA;
                    opb_d    = in_opB;
                    rd_d     = in_rd;
                    is_div_d = (in_opcode == OP_DIV);
                    mult_d   = (in_opcode != OP_DIV);
                    div_d    = (in_opcode == OP_DIV);
                end
            end
            START: begin
                stall   = 1'b1;
                state_d = flush ? DRAIN : BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = md.md_resultRDY ? IDLE : DRAIN;
                end else if (md.md_resultRDY || tmo_hit) begin
                    state_d  = DONE;
                    wbv_d    = 1'b1;
                    wbwe_d   = (fmt_rd != 5'd0);
                    wbrd_d   = fmt_rd;
                    wbdata_d = fmt_data;
                    wbexc_d  = fmt_exc_o;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                stall = is_md;
                if (md.md_resultRDY || tmo_hit) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            rd_q     <= 5'd0;
            is_div_q <= 1'b0;
            mult_q   <= 1'b0;
            div_q    <= 1'b0;
            wbv_q    <= 1'b0;
            wbwe_q   <= 1'b0;
            wbrd_q   <= 5'd0;
            wbdata_q <= 32'd0;
            wbexc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rd_q     <= rd_d;
            is_div_q <= is_div_d;
            mult_q   <= mult_d;
            div_q    <= div_d;
            wbv_q    <= wbv_d;
            wbwe_q   <= wbwe_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            wbexc_q  <= wbexc_d;
        end
    end

    assign md.md_opA     = opa_q;
    assign md.md_opB     = opb_q;
    assign md.ctrl_MULT  = mult_q;
    assign md.ctrl_DIV   = div_q;

    // A flush landing on the retire cycle squashes the write
    assign wb_valid     = wbv_q & ~flush;
    assign wb_we        = wbwe_q & ~flush;
    assign wb_rd        = wbrd_q;
    assign wb_data      = wbdata_q;
    assign wb_exception = wbexc_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed, table-driven bench for md_issue_ctrl: one table row per clock cycle.
// Rows hold the inputs for that cycle and the outputs expected in that same cycle.
module tb_md_issue_ctrl;

    localparam logic [4:0] M   = 5'b00110;
    localparam logic [4:0] D   = 5'b00111;
    localparam logic [4:0] ADD = 5'b00000;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_opcode;
    logic [31:0] in_opA;
    logic [31:0] in_opB;
    logic [4:0]  in_rd;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    md_issue_ctrl_if mdif ();

    md_issue_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_opcode    (in_opcode),
        .in_opA       (in_opA),
        .in_opB       (in_opB),
        .in_rd        (in_rd),
        .flush        (flush),
        .stall        (stall),
        .md           (mdif),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        fl;
        logic        irdy;
        logic        rrdy;
        logic [31:0] res;
        logic        exc;
        logic        e_st;
        logic        e_mul;
        logic        e_div;
        logic        e_wbv;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_exc;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input int iv, input int op, input int a, input int b, input int rd,
        input int fl, input int irdy, input int rrdy, input int res, input int exc,
        input int st, input int mul, input int dv, input int wbv, input int we,
        input int wrd, input int wdata, input int wexc
    );
        vec_t r;
        r.iv     = 1'(iv);
        r.op     = 5'(op);
        r.a      = 32'(a);
        r.b      = 32'(b);
        r.rd     = 5'(rd);
        r.fl     = 1'(fl);
        r.irdy   = 1'(irdy);
        r.rrdy   = 1'(rrdy);
        r.res    = 32'(res);
        r.exc    = 1'(exc);
        r.e_st   = 1'(st);
        r.e_mul  = 1'(mul);
        r.e_div  = 1'(dv);
        r.e_wbv  = 1'(wbv);
        r.e_we   = 1'(we);
        r.e_rd   = 5'(wrd);
        r.e_data = 32'(wdata);
        r.e_exc  = 1'(wexc);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        in_valid          = t.iv;
        in_opcode         = t.op;
        in_opA            = t.a;
        in_opB            = t.b;
        in_rd             = t.rd;
        flush             = t.fl;
        mdif.md_inputRDY  = t.irdy;
        mdif.md_resultRDY = t.rrdy;
        mdif.md_result    = t.res;
        mdif.md_exception = t.exc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(mk(0, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // MUL 7x6 rd3, result three cycles after the pulse
        tbl.push_back(mk(1, M, 7, 6, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 7, 6, 3, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 7, 6, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 7, 6, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 7, 6, 3, 0, 1, 1, 42, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 7, 6, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 42, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // DIV 9/0 rd7 with exception; resultRDY during START ignored
        tbl.push_back(mk(1, D, 9, 0, 7, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, D, 9, 0, 7, 0, 1, 1, 99, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, D, 9, 0, 7, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, D, 9, 0, 7, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, D, 9, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 30, 5, 1));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // multdiv not ready for four cycles
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, M, 5, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 5, 5, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 5, 5, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 5, 5, 1, 0, 1, 1, 25, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 5, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 25, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // flush in second BUSY cycle, drain, then a normal MUL
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 3, 3, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4, 9, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // single-cycle ADD bypasses the sequencer
        tbl.push_back(mk(1, ADD, 1, 2, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ADD, 1, 2, 5, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // rd = 0: strobe without write enable
        tbl.push_back(mk(1, M, 2, 3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 2, 3, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 2, 3, 0, 0, 1, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 2, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // resultRDY and flush together in BUSY
        tbl.push_back(mk(1, M, 4, 4, 5, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 4, 4, 5, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 1, 1, 16, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 4, 4, 5, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 4, 4, 5, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 4, 4, 5, 0, 1, 1, 16, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 4, 4, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 16, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // flush on the retire cycle suppresses the strobe
        tbl.push_back(mk(1, D, 8, 2, 6, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, D, 8, 2, 6, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, D, 8, 2, 6, 0, 1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // flush in IDLE blocks issue
        tbl.push_back(mk(1, M, 1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 1, 1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 1, 1, 2, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 1, 1, 2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, M, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // flush during START goes to DRAIN
        tbl.push_back(mk(1, M, 1, 1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset ctrl_MULT", {31'd0, mdif.ctrl_MULT}, 32'd0);
        chk("reset ctrl_DIV", {31'd0, mdif.ctrl_DIV}, 32'd0);
        chk("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset md_opA", mdif.md_opA, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].e_st});
            chk($sformatf("row%0d ctrl_MULT", i), {31'd0, mdif.ctrl_MULT}, {31'd0, tbl[i].e_mul});
            chk($sformatf("row%0d ctrl_DIV", i), {31'd0, mdif.ctrl_DIV}, {31'd0, tbl[i].e_div});
            chk($sformatf("row%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, tbl[i].e_wbv});
            chk($sformatf("row%0d wb_we", i), {31'd0, wb_we}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_wbv) begin
                chk($sformatf("row%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, tbl[i].e_rd});
                chk($sformatf("row%0d wb_data", i), wb_data, tbl[i].e_data);
                chk($sformatf("row%0d wb_exc", i), {31'd0, wb_exception}, {31'd0, tbl[i].e_exc});
            end
        end

        // reset asserted mid-BUSY, later resultRDY ignored
        @(negedge clock);
        drive(mk(1, M, 11, 12, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        #1;
        chk("hold md_opA", mdif.md_opA, 32'd11);
        chk("hold md_opB", mdif.md_opB, 32'd12);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mdif.md_resultRDY = 1'b1;
        mdif.md_result    = 32'd77;
        #1;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst ctrl_MULT", {31'd0, mdif.ctrl_MULT}, 32'd0);
        chk("rst md_opA", mdif.md_opA, 32'd0);
        chk("rst md_opB", mdif.md_opB, 32'd0);
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst wb_rd", {27'd0, wb_rd}, 32'd0);
        @(negedge clock);
        mdif.md_resultRDY = 1'b0;
        #1;
        chk("post-rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("post-rst stall", {31'd0, stall}, 32'd0);
        in_valid = 1'b1;
        @(negedge clock);
        #1;
        chk("reissue ctrl_MULT", {31'd0, mdif.ctrl_MULT}, 32'd1);
        in_valid = 1'b0;

`ifdef MD_TIMEOUT_EN
        begin
            int n;
            n = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clock);
                #1;
                if (wb_valid) break;
                n++;
            end
            chk("tmo wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("tmo busy cycles", n, 32'd64);
            chk("tmo wb_exc", {31'd0, wb_exception}, 32'd1);
            chk("tmo wb_rd", {27'd0, wb_rd}, 32'd30);
            chk("tmo wb_data", wb_data, 32'd4);
        end
`else
        @(negedge clock);
        mdif.md_resultRDY = 1'b1;
        mdif.md_result    = 32'd132;
        @(negedge clock);
        mdif.md_resultRDY = 1'b0;
        #1;
        chk("reissue wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("reissue wb_rd", {27'd0, wb_rd}, 32'd9);
        chk("reissue wb_data", wb_data, 32'd132);
`endif

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
